// File: rtl/instruction_queue_unit_if.sv
// Decode-to-dispatch instruction queue bus.
//   master : producer/consumer side (drives valid_in, packet_in, flush, dispatch_ready)
//   slave  : the queue (drives valid_out, packet_out, stall_decode, queue_full, count, overflow)
interface instruction_queue_unit_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned QUEUE_DEPTH  = 8
);
    localparam int unsigned PACKET_WIDTH = DATA_WIDTH + ADDRESS_BITS * 3 + 38;
    localparam int unsigned CNT_W        = $clog2(QUEUE_DEPTH) + 1;

    logic                    valid_in;
    logic [PACKET_WIDTH-1:0] packet_in;
    logic                    flush;
    logic                    dispatch_ready;
    logic                    valid_out;
    logic [PACKET_WIDTH-1:0] packet_out;
    logic                    stall_decode;
    logic                    queue_full;
    logic [CNT_W-1:0]        count;
    logic                    overflow;

    modport master (
        output valid_in, packet_in, flush, dispatch_ready,
        input  valid_out, packet_out, stall_decode, queue_full, count, overflow
    );

    modport slave (
        input  valid_in, packet_in, flush, dispatch_ready,
        output valid_out, packet_out, stall_decode, queue_full, count, overflow
    );
endinterface

// File: rtl/instruction_queue_unit.sv
// Circular FIFO between decode and out-of-order dispatch.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   q_if (slave) : valid_in/packet_in push, dispatch_ready pops the head,
//                  flush discards all entries; valid_out/packet_out present the
//                  oldest entry; stall_decode, queue_full, count, sticky overflow.
module instruction_queue_unit #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned QUEUE_DEPTH  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    instruction_queue_unit_if.slave  q_if
);
    localparam int unsigned PACKET_WIDTH = DATA_WIDTH + ADDRESS_BITS * 3 + 38;
    localparam int unsigned PTR_W        = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W        = PTR_W + 1;

    logic [PACKET_WIDTH-1:0] mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    overflow_q, overflow_d;

    logic valid_c;
    logic full_c;
    logic pop_c;
    logic push_c;
    logic wr_en_c;

    assign valid_c = (count_q != '0);
    assign full_c  = (count_q == CNT_W'(QUEUE_DEPTH));
    assign pop_c   = valid_c && q_if.dispatch_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_c  = q_if.valid_in && (!full_c || pop_c);
    assign wr_en_c = push_c && !q_if.flush;

    // Next-state for pointers, occupancy and sticky overflow; flush dominates.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (q_if.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (q_if.valid_in && full_c && !pop_c) overflow_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; only occupied slots are ever presented.
    always_ff @(posedge clock) begin
        if (wr_en_c && !reset) mem_q[wr_ptr_q] <= q_if.packet_in;
    end

    assign q_if.valid_out    = valid_c;
    assign q_if.packet_out   = valid_c ? mem_q[rd_ptr_q] : '0;
    assign q_if.queue_full   = full_c;
    // Two slots of slack cover the packet in the decode register and one more in flight.
    assign q_if.stall_decode = (count_q >= CNT_W'(QUEUE_DEPTH - 2));
    assign q_if.count        = count_q;
    assign q_if.overflow     = overflow_q;
endmodule

// File: tb/tb_instruction_queue_unit.sv
// Self-checking bench for instruction_queue_unit at QUEUE_DEPTH=4 against a
// queue-based reference model.
module tb_instruction_queue_unit;
    localparam int unsigned DW = 32;
    localparam int unsigned AB = 20;
    localparam int unsigned QD = 4;
    localparam int unsigned PW = DW + AB * 3 + 38;
    localparam int unsigned CW = $clog2(QD) + 1;

    logic clock;
    logic reset;

    instruction_queue_unit_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .QUEUE_DEPTH(QD)) iq ();

    instruction_queue_unit #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .QUEUE_DEPTH(QD)) dut (
        .clock (clock),
        .reset (reset),
        .q_if  (iq.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;

    logic [PW-1:0] mq[$];
    bit            m_ovf = 1'b0;

    function automatic logic [PW-1:0] m_head();
        if (mq.size() == 0) return '0;
        return mq[0];
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample #1 after.
    task automatic tick(input logic vin, input logic [PW-1:0] pkt, input logic fl,
                        input logic dr, input logic rst);
        bit do_pop, do_push;
        iq.valid_in       = vin;
        iq.packet_in      = pkt;
        iq.flush          = fl;
        iq.dispatch_ready = dr;
        reset             = rst;
        @(posedge clock);
        do_pop  = (mq.size() != 0) && dr;
        do_push = vin && ((mq.size() < QD) || do_pop);
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (vin && (mq.size() == QD) && !do_pop) m_ovf = 1'b1;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(pkt);
        end
        #1;
    endtask

    task automatic idle();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [PW-1:0] pkt, input logic dr);
        tick(1'b1, pkt, 1'b0, dr, 1'b0);
    endtask

    task automatic test_reset();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();
        vectors++; if (iq.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", iq.valid_out); end
        vectors++; if (iq.count !== CW'(0)) begin errors++; $display("FAIL reset_count got=%0d exp=0", iq.count); end
        vectors++; if (iq.packet_out !== PW'(0)) begin errors++; $display("FAIL reset_packet got=%h exp=0", iq.packet_out); end
        vectors++; if (iq.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", iq.overflow); end
        vectors++; if (iq.stall_decode !== 1'b0 || iq.queue_full !== 1'b0) begin errors++; $display("FAIL reset_stall_full got=%b%b exp=00", iq.stall_decode, iq.queue_full); end
    endtask

    task automatic test_fill();
        push(PW'(1), 1'b0);
        vectors++; if (iq.valid_out !== 1'b1) begin errors++; $display("FAIL fill_valid got=%b exp=1", iq.valid_out); end
        vectors++; if (iq.stall_decode !== 1'b0) begin errors++; $display("FAIL fill_stall1 got=%b exp=0", iq.stall_decode); end
        push(PW'(2), 1'b0);
        vectors++; if (iq.stall_decode !== 1'b1) begin errors++; $display("FAIL fill_stall2 got=%b exp=1", iq.stall_decode); end
        push(PW'(3), 1'b0);
        vectors++; if (iq.count !== CW'(3)) begin errors++; $display("FAIL fill_count got=%0d exp=3", iq.count); end
        vectors++; if (iq.packet_out !== PW'(1)) begin errors++; $display("FAIL fill_head got=%h exp=1", iq.packet_out); end
    endtask

    task automatic test_overflow();
        push(PW'(4), 1'b0);
        vectors++; if (iq.queue_full !== 1'b1 || iq.count !== CW'(4)) begin errors++; $display("FAIL ovf_full got=%b/%0d exp=1/4", iq.queue_full, iq.count); end
        vectors++; if (iq.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", iq.overflow); end
        push(PW'(5), 1'b0);
        vectors++; if (iq.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", iq.overflow); end
        vectors++; if (iq.count !== CW'(4) || iq.packet_out !== PW'(1)) begin errors++; $display("FAIL ovf_state got=%0d/%h exp=4/1", iq.count, iq.packet_out); end
        idle();
        vectors++; if (iq.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", iq.overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [PW-1:0] exp_order [4];
        exp_order[0] = PW'(2); exp_order[1] = PW'(3); exp_order[2] = PW'(4); exp_order[3] = PW'(6);
        push(PW'(6), 1'b1);
        vectors++; if (iq.count !== CW'(4) || iq.packet_out !== PW'(2)) begin errors++; $display("FAIL fpp_state got=%0d/%h exp=4/2", iq.count, iq.packet_out); end
        vectors++; if (iq.overflow !== 1'b1) begin errors++; $display("FAIL fpp_ovf got=%b exp=1", iq.overflow); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (iq.packet_out !== exp_order[i] || iq.valid_out !== 1'b1) begin errors++; $display("FAIL drain_%0d got=%h exp=%h", i, iq.packet_out, exp_order[i]); end
            tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        vectors++; if (iq.valid_out !== 1'b0 || iq.packet_out !== PW'(0)) begin errors++; $display("FAIL drain_empty got=%b/%h exp=0/0", iq.valid_out, iq.packet_out); end
    endtask

    task automatic test_wraparound();
        for (int i = 0; i < 10; i++) begin
            push(PW'(16 + i), 1'b1);
            vectors++; if (iq.packet_out !== PW'(16 + i) || iq.count !== CW'(1)) begin errors++; $display("FAIL wrap_%0d got=%h/%0d exp=%h/1", i, iq.packet_out, iq.count, PW'(16 + i)); end
        end
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        vectors++; if (iq.valid_out !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%b exp=0", iq.valid_out); end
    endtask

    task automatic test_flush();
        push(PW'(9), 1'b0); push(PW'(10), 1'b0); push(PW'(11), 1'b0);
        tick(1'b1, PW'(7), 1'b1, 1'b1, 1'b0);
        vectors++; if (iq.count !== CW'(0) || iq.valid_out !== 1'b0) begin errors++; $display("FAIL flush_clear got=%0d/%b exp=0/0", iq.count, iq.valid_out); end
        vectors++; if (iq.overflow !== 1'b1) begin errors++; $display("FAIL flush_ovf got=%b exp=1", iq.overflow); end
        push(PW'(8), 1'b0);
        vectors++; if (iq.packet_out !== PW'(8) || iq.count !== CW'(1)) begin errors++; $display("FAIL flush_next got=%h/%0d exp=8/1", iq.packet_out, iq.count); end
    endtask

    task automatic test_reset_midstream();
        push(PW'(12), 1'b0);
        vectors++; if (iq.count !== CW'(2) || iq.overflow !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%0d/%b exp=2/1", iq.count, iq.overflow); end
        tick(1'b1, PW'(13), 1'b1, 1'b1, 1'b1);
        vectors++; if (iq.count !== CW'(0) || iq.valid_out !== 1'b0 || iq.overflow !== 1'b0) begin errors++; $display("FAIL rstmid_state got=%0d/%b/%b exp=0/0/0", iq.count, iq.valid_out, iq.overflow); end
        vectors++; if (iq.stall_decode !== 1'b0 || iq.packet_out !== PW'(0)) begin errors++; $display("FAIL rstmid_out got=%b/%h exp=0/0", iq.stall_decode, iq.packet_out); end
    endtask

    task automatic test_random();
        logic [PW-1:0] pkt;
        logic          vin, fl, dr, rst;
        for (int c = 0; c < 600; c++) begin
            pkt = PW'({$urandom, $urandom, $urandom, $urandom, $urandom});
            vin = ($urandom_range(0, 99) < 70);
            dr  = ($urandom_range(0, 99) < 45);
            fl  = ($urandom_range(0, 99) < 4);
            rst = ($urandom_range(0, 199) < 2);
            tick(vin, pkt, fl, dr, rst);
            vectors++; if (iq.count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, iq.count, mq.size()); end
            vectors++; if (iq.valid_out !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, iq.valid_out, mq.size() != 0); end
            vectors++; if (iq.packet_out !== m_head()) begin errors++; $display("FAIL rnd_packet cyc=%0d got=%h exp=%h", c, iq.packet_out, m_head()); end
            vectors++; if (iq.queue_full !== (mq.size() == QD)) begin errors++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", c, iq.queue_full, mq.size() == QD); end
            vectors++; if (iq.stall_decode !== (mq.size() >= QD - 2)) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, iq.stall_decode, mq.size() >= QD - 2); end
            vectors++; if (iq.overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", c, iq.overflow, m_ovf); end
        end
    endtask

    initial begin
        reset             = 1'b1;
        iq.valid_in       = 1'b0;
        iq.packet_in      = '0;
        iq.flush          = 1'b0;
        iq.dispatch_ready = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_wraparound();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/instruction_queue_unit.md
Name: instruction_queue_unit

Overview:
- Circular FIFO that buffers decoded instruction packets from the decode pipeline register and presents them, oldest first, to the out-of-order dispatch/issue logic.
- Gives back-pressure to fetch/decode through a stall output with slack for the in-flight decode register.
- Discards its whole contents on a control-flow redirect flush from writeback.

Parameters:
- DATA_WIDTH, 32: datapath width. Sets the packet width.
- ADDRESS_BITS, 20: PC/address width. Sets the packet width.
- QUEUE_DEPTH, 8: number of entries. Must be a power of two and at least 4.
- PACKET_WIDTH (derived localparam, not overridable): DATA_WIDTH + ADDRESS_BITS*3 + 38, which is 130 at the defaults.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  packet_in holds a valid decoded packet this cycle.
- packet_in  in  PACKET_WIDTH  decoded instruction packet.
- flush  in  1  redirect from writeback (taken branch or JALR); discard all entries.
- dispatch_ready  in  1  consumer accepts the head entry this cycle.
- valid_out  out  1  queue is non-empty; packet_out is valid.
- packet_out  out  PACKET_WIDTH  head (oldest) entry; all zeros when empty.
- stall_decode  out  1  asks upstream to stop issuing packets.
- queue_full  out  1  count == QUEUE_DEPTH.
- count  out  log2(QUEUE_DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky error: a push was dropped.

Behaviour:
- Reset (synchronous, active-high): rd_ptr=0, wr_ptr=0, count=0, overflow=0. As a result valid_out=0, packet_out=0, queue_full=0, stall_decode=0. Storage contents are don't-care.
- Pop: pop = valid_out && dispatch_ready. Asserting dispatch_ready while empty has no effect.
- Push: push = valid_in && (!queue_full || pop).
  - Writes packet_in at wr_ptr.
  - Increments wr_ptr modulo QUEUE_DEPTH (natural wrap, no special case).
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - This is legal when full: the head leaves and the new packet enters the freed slot.
- Empty with push: no bypass. A packet written at edge N appears on valid_out/packet_out after edge N (one-cycle latency). The consumer must not see it in the same cycle.
- Count update: count <= count + push - pop.
- Outputs are combinational from registered state:
  - valid_out = (count != 0).
  - packet_out = mem[rd_ptr] when valid_out, else 0.
  - queue_full = (count == QUEUE_DEPTH).
  - stall_decode = (count >= QUEUE_DEPTH-2). This leaves two free slots for the packet sitting in the decode register plus one launched in the same cycle.
- Overflow:
  - Condition: valid_in && queue_full && !pop.
  - The packet is dropped, state is unchanged, and overflow is set to 1.
  - overflow stays at 1 until reset; flush does not clear it.
- Flush has the highest priority, after reset:
  - rd_ptr, wr_ptr and count go to 0.
  - A push or pop requested in the same cycle is ignored; the incoming packet is dropped and the head is not consumed.
  - This dropped push does not set overflow.
  - valid_out is 0 on the following cycle.
- Reset while a flush, push or pop is pending: reset wins and all state takes its reset values.
- There is no state machine beyond pointers and count. Every condition above is evaluated per cycle.

Test Plan (QUEUE_DEPTH=4 unless stated):
- Reset, then push packets A=0x1, B=0x2, C=0x3 on consecutive cycles with dispatch_ready=0 -> valid_out rises the cycle after A is pushed; count reaches 3; stall_decode=1 once count=2; packet_out=0x1.
- Continue from 3 entries: push D=0x4, then push E=0x5 with dispatch_ready=0 -> queue_full=1 and count=4; E is dropped; overflow=1 and stays 1; packet_out stays 0x1.
- Full queue, valid_in=1 with F=0x6 and dispatch_ready=1 in the same cycle -> head 0x1 popped, F written, count stays 4, overflow unchanged. Then drain with dispatch_ready=1 -> order is 0x2, 0x3, 0x4, 0x6, then valid_out=0 and packet_out=0.
- Wrap-around: push and pop 10 packets 0x10..0x19 continuously with dispatch_ready=1 -> all delivered in order, each packet appearing one cycle after its push, count never above 1, pointers wrap twice with no loss.
- Queue holding 3 entries, flush=1 with valid_in=1 (packet 0x7) and dispatch_ready=1 -> next cycle count=0, valid_out=0; 0x7 is never output; overflow unchanged. A push the cycle after the flush appears one cycle later as the head.
- reset=1 asserted while holding 2 entries and overflow=1 -> next cycle count=0, valid_out=0, overflow=0, stall_decode=0, packet_out=0.
